pipeline_skid_stage: RTL

//  - Elastic ready/valid pipeline register with backpressure. It is the consumer-side counterpart of the

---
 rtl/pipeline_skid_stage.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/pipeline_skid_stage.sv
// pipeline_skid_stage: elastic ready/valid register stage with a 2-entry skid
// buffer. It sits between DSP48A1 result registers and a consumer that may stall.
// IN_READY and OUT_VALID are decoded only from the state register, so neither
// output has a combinational path from the other side of the stage.
//
// Optional feature macro: PIPE_STALL_CNT_EN
//   defined   -> STALL_CNT port and a saturating output-stall counter are present
//   undefined -> no STALL_CNT port and no counter; data behaviour is unchanged

module pipeline_skid_stage #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     DATA_IN,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  output logic [WIDTH-1:0]     DATA_OUT,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] STALL_CNT
`endif
);

  // EMPTY: nothing held. BUSY: out_reg valid. FULL: out_reg and skid_reg valid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BUSY  = 2'b01,
    ST_FULL  = 2'b10
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [WIDTH-1:0]   out_reg_r;
  logic [WIDTH-1:0]   skid_reg_r;
  logic [WIDTH-1:0]   out_nxt_s;
  logic               acc_in_s;
  logic               acc_out_s;
  logic               load_out_s;
  logic               load_skid_s;
  logic               out_from_skid_s;
  logic               in_ready_s;
  logic               out_valid_s;

  // Handshake flags decoded from the registered state only.
  always_comb begin
    in_ready_s  = (state_r != ST_FULL);
    out_valid_s = (state_r != ST_EMPTY);
    acc_in_s    = IN_VALID && in_ready_s;
    acc_out_s   = out_valid_s && OUT_READY;
  end

  assign IN_READY  = in_ready_s;
  assign OUT_VALID = out_valid_s;
  assign DATA_OUT  = out_reg_r;

  // State register; reset wins over any transfer in the same cycle.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode and register load enables.
  always_comb begin
    state_nxt_s     = state_r;
    load_out_s      = 1'b0;
    load_skid_s     = 1'b0;
    out_from_skid_s = 1'b0;
    case (state_r)
      ST_EMPTY: begin
        if (acc_in_s) begin
          load_out_s  = 1'b1;
          state_nxt_s = ST_BUSY;
        end else begin
          state_nxt_s = ST_EMPTY;
        end
      end
      ST_BUSY: begin
        if (acc_in_s && acc_out_s) begin
          // Pass-through: the sink takes the old word as the new one lands.
          load_out_s  = 1'b1;
          state_nxt_s = ST_BUSY;
        end else if (acc_in_s) begin
          // Sink stalled: park the incoming word in the skid register.
          load_skid_s = 1'b1;
          state_nxt_s = ST_FULL;
        end else if (acc_out_s) begin
          state_nxt_s = ST_EMPTY;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      ST_FULL: begin
        // IN_READY is low here, so upstream data is never taken.
        if (acc_out_s) begin
          load_out_s      = 1'b1;
          out_from_skid_s = 1'b1;
          state_nxt_s     = ST_BUSY;
        end else begin
          state_nxt_s = ST_FULL;
        end
      end
      default: begin
        state_nxt_s = ST_EMPTY;
      end
    endcase
  end

  // Select the source feeding out_reg: skid word when draining FULL, else input.
  always_comb begin
    if (out_from_skid_s) begin
      out_nxt_s = skid_reg_r;
    end else begin
      out_nxt_s = DATA_IN;
    end
  end

  // Output data register; holds its last value whenever not loaded.
  always_ff @(posedge CLK) begin
    if (reset) begin
      out_reg_r <= {WIDTH{1'b0}};
    end else if (load_out_s) begin
      out_reg_r <= out_nxt_s;
    end else begin
      out_reg_r <= out_reg_r;
    end
  end

  // Skid register; captures the second word only when the sink is stalled.
  always_ff @(posedge CLK) begin
    if (reset) begin
      skid_reg_r <= {WIDTH{1'b0}};
    end else if (load_skid_s) begin
      skid_reg_r <= DATA_IN;
    end else begin
      skid_reg_r <= skid_reg_r;
    end
  end

`ifdef PIPE_STALL_CNT_EN
  logic [CNT_WIDTH-1:0] stall_cnt_r;
  logic                 stall_s;
  logic                 cnt_sat_s;

  // A stall cycle is one where a valid word is presented but not taken.
  always_comb begin
    stall_s   = out_valid_s && !OUT_READY;
    cnt_sat_s = (stall_cnt_r == {CNT_WIDTH{1'b1}});
  end

  // Saturating stall counter, cleared only by reset.
  always_ff @(posedge CLK) begin
    if (reset) begin
      stall_cnt_r <= {CNT_WIDTH{1'b0}};
    end else if (stall_s && !cnt_sat_s) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign STALL_CNT = stall_cnt_r;
`endif

endmodule
